// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MDU op codes, FSM states and op-class decode; MADD family decoded only with MDU_MADD_EN.
package mdu_ctrl_pkg;
  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MFHI  = 4'd4;
  localparam logic [3:0] MDU_MFLO  = 4'd5;
  localparam logic [3:0] MDU_MTHI  = 4'd6;
  localparam logic [3:0] MDU_MTLO  = 4'd7;
  localparam logic [3:0] MDU_MADD  = 4'd8;
  localparam logic [3:0] MDU_MADDU = 4'd9;
  localparam logic [3:0] MDU_MSUB  = 4'd10;
  localparam logic [3:0] MDU_MSUBU = 4'd11;
  typedef enum logic {MDU_IDLE, MDU_RUN} mdu_state_e;
  function automatic logic is_div(input logic [3:0] op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction
  function automatic logic is_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op[3:2] == 2'b00 || op[3:2] == 2'b10;
`else
    return op[3:2] == 2'b00;
`endif
  endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage MDU issue/result bundle between the pipeline (master) and the MDU (slave).
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_mdu;
  logic        busy;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output start, mdu_op, rs_val, rt_val, d_uses_mdu, input busy, stall, rd_data, hi, lo);
  modport slave(input start, mdu_op, rs_val, rt_val, d_uses_mdu, output busy, stall, rd_data, hi, lo);
endinterface

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational MDU datapath producing {hi,lo} after commit; accumulate path only with MDU_MADD_EN.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);
  logic        sgn, sa, sb, dz;
  logic [31:0] ua, ub, uq, ur;
  logic [63:0] prod, div_res;
  assign sgn = ~op[0];
  assign sa = sgn & a[31];
  assign sb = sgn & b[31];
  assign ua = sa ? -a : a;
  assign ub = sb ? -b : b;
  assign dz = b == 32'd0;
  assign uq = dz ? 32'd0 : ua / ub;
  assign ur = dz ? 32'd0 : ua % ub;
  assign prod = {{32{sa}}, a} * {{32{sb}}, b};
  // remainder follows the dividend sign, quotient truncates toward zero
  assign div_res = dz ? {hi, lo} : {sa ? -ur : ur, (sa ^ sb) ? -uq : uq};
`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = op[1] ? {hi, lo} - prod : {hi, lo} + prod;
  assign res = is_div(op) ? div_res : op[3] ? acc : prod;
`else
  assign res = is_div(op) ? div_res : prod;
`endif
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with HI/LO and stall request; MDU_MADD_EN enables MADD/MSUB family.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);
  mdu_state_e  state, state_n;
  logic [3:0]  cnt, cnt_n, op_q;
  logic [31:0] a_q, b_q, hi, lo;
  logic [63:0] res;
  logic        idle, go, done, mt;
  assign idle = state == MDU_IDLE;
  assign mt = idle & bus.start;
  assign go = mt & is_long(bus.mdu_op);
  assign done = !idle && cnt == 4'd1;
  always_comb begin
    state_n = go ? MDU_RUN : done ? MDU_IDLE : state;
    cnt_n = go ? (is_div(bus.mdu_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : idle ? cnt : cnt - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MDU_IDLE;
      cnt <= 4'd0;
      op_q <= 4'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (go) begin
        op_q <= bus.mdu_op;
        a_q <= bus.rs_val;
        b_q <= bus.rt_val;
      end
      if (done) {hi, lo} <= res;
      else if (mt && bus.mdu_op == MDU_MTHI) hi <= bus.rs_val;
      else if (mt && bus.mdu_op == MDU_MTLO) lo <= bus.rs_val;
    end
  end
  mdu_arith u_arith (.op(op_q), .a(a_q), .b(b_q), .hi(hi), .lo(lo), .res(res));
  assign bus.busy = !idle;
  assign bus.stall = bus.d_uses_mdu & (!idle | (bus.start & is_long(bus.mdu_op)));
  assign bus.rd_data = bus.mdu_op == MDU_MFHI ? hi : bus.mdu_op == MDU_MFLO ? lo : 32'd0;
  assign bus.hi = hi;
  assign bus.lo = lo;
endmodule
